instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/mccoy_pkg.sv | 28 ++
 rtl/prog_mem.sv | 48 ++++
 rtl/instr_sequencer.sv | 94 +++++++++
 tb/tb_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mccoy_pkg.sv
// rtl/mccoy_pkg.sv - shared widths, opcodes and sequencer state encoding
package mccoy_pkg;

  localparam int INSTR_W   = 8;
  localparam int PC_W      = 4;
  localparam int MEM_DEPTH = 16;

  localparam logic [2:0] LI   = 3'd0;
  localparam logic [2:0] JA   = 3'd1;
  localparam logic [2:0] BEZ  = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] LR   = 3'd4;
  localparam logic [2:0] NOT  = 3'd5;
  localparam logic [2:0] SR   = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  // Power-on fill for memory and instruction register: a halt with operand 0.
  localparam logic [INSTR_W-1:0] HALT_INSTR = {HALT, 5'd0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - 16x8 program store with MSB-first serial write port
module prog_mem
  import mccoy_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_shift_en,
  input  logic               i_ser_in,
  input  logic [PC_W-1:0]    i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data
);

  logic [INSTR_W-1:0] r_mem [MEM_DEPTH];
  logic [INSTR_W-1:0] r_shift;
  logic [2:0]         r_bit_cnt;
  logic [PC_W-1:0]    r_wr_ptr;
  logic [INSTR_W-1:0] w_byte;

  // The byte completing on this edge already includes the incoming bit.
  assign w_byte = {r_shift[INSTR_W-2:0], i_ser_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= HALT_INSTR;
      end
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_wr_ptr  <= '0;
    end else if (i_clear) begin
      r_bit_cnt <= '0;
      r_wr_ptr  <= '0;
    end else if (i_shift_en) begin
      r_shift <= w_byte;
      if (r_bit_cnt == 3'd7) begin
        r_mem[r_wr_ptr] <= w_byte;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_bit_cnt       <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/exec sequencer with serial program load
module instr_sequencer
  import mccoy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic       ser_in,
  input  logic       ser_valid,
  input  logic       run,
  input  logic       ja,
  input  logic       bez,
  input  logic       zero,
  output logic [2:0] opcode,
  output logic [4:0] operand,
  output logic       instr_valid,
  output logic [3:0] pc,
  output logic       halted,
  output logic       loading
);

  state_t             r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic [INSTR_W-1:0] w_mem_data;
  logic               w_take;

  // Leaving LOAD keeps the write pointer and bit counter cleared, so any
  // partial byte is dropped and the next load session starts at mem[0].
  prog_mem u_prog_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (r_state != S_LOAD),
    .i_shift_en ((r_state == S_LOAD) && load_en && ser_valid),
    .i_ser_in   (ser_in),
    .i_rd_addr  (r_pc),
    .o_rd_data  (w_mem_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= HALT_INSTR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // ja wins over bez; both arrive combinationally from the decoder.
  assign w_take = ja || (bez && zero);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    if (load_en) begin
      w_state_next = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (run) begin
            w_state_next = S_FETCH;
            w_pc_next    = '0;
          end
        end
        S_LOAD: w_state_next = S_IDLE;
        S_FETCH: begin
          w_ir_next    = w_mem_data;
          w_state_next = S_EXEC;
        end
        S_EXEC: begin
          if (r_ir[7:5] == HALT) begin
            w_state_next = S_HALT;
          end else begin
            w_state_next = S_FETCH;
            w_pc_next    = w_take ? r_ir[PC_W-1:0] : r_pc + 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign opcode      = r_ir[7:5];
  assign operand     = r_ir[4:0];
  assign pc          = r_pc;
  assign instr_valid = (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);
  assign loading     = (r_state == S_LOAD);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed and randomized checks against a program-level model
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       ja_drv = 1'b0;
  logic       bez_drv = 1'b0;
  logic       use_dec = 1'b1;
  logic       ja, bez;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       instr_valid, halted, loading;
  logic [3:0] pc;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mem_m [16];
  logic [7:0] prog_q [$];
  logic [2:0] safe_ops [5];

  always #5 clk = ~clk;

  // Stand-in decoder: jump/branch controls from the live opcode, or raw drives.
  assign ja  = use_dec ? (instr_valid && opcode == 3'd1) : ja_drv;
  assign bez = use_dec ? (instr_valid && opcode == 3'd2) : bez_drv;

  instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .run         (run),
    .ja          (ja),
    .bez         (bez),
    .zero        (zero),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .loading     (loading)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'hE0;
  endtask

  // Shift prog_q in MSB first with random idle gaps, then 'partial' stray bits.
  task automatic load_prog(input int partial);
    int         wp;
    logic [7:0] pb;
    wp = 0;
    load_en = 1'b1;
    tick();
    check("load_entered", 32'(loading), 32'd1);
    for (int k = 0; k < prog_q.size(); k++) begin
      for (int b = 7; b >= 0; b--) begin
        if ($urandom_range(3) == 0) begin
          ser_valid = 1'b0;
          tick();
        end
        ser_in    = prog_q[k][b];
        ser_valid = 1'b1;
        tick();
      end
      mem_m[wp] = prog_q[k];
      wp = (wp + 1) % 16;
    end
    pb = 8'($urandom);
    for (int b = 0; b < partial; b++) begin
      ser_in    = pb[7-b];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    load_en   = 1'b0;
    tick();
    check("load_exit_idle", 32'(loading), 32'd0);
  endtask

  // zmode: 0 zero low, 1 zero high, 2 random. dec=0 drives ja/bez/run randomly.
  task automatic run_and_check(input int nsteps, input bit dec, input int zmode);
    int         mpc;
    logic [7:0] ins;
    bit         jv, bv, zv;
    use_dec = dec;
    mpc = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("fetch_iv", 32'(instr_valid), 32'd0);
    check("fetch_pc0", 32'(pc), 32'd0);
    for (int s = 0; s < nsteps; s++) begin
      tick();
      ins = mem_m[mpc];
      check("exec_iv", 32'(instr_valid), 32'd1);
      check("exec_pc", 32'(pc), 32'(mpc));
      check("exec_opcode", 32'(opcode), 32'(ins[7:5]));
      check("exec_operand", 32'(operand), 32'(ins[4:0]));
      if (ins[7:5] == 3'd7) begin
        run = 1'b0;
        tick();
        check("halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'(mpc));
        check("halt_iv", 32'(instr_valid), 32'd0);
        return;
      end
      zv   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      zero = zv;
      if (dec) begin
        jv = (ins[7:5] == 3'd1);
        bv = (ins[7:5] == 3'd2);
      end else begin
        jv      = 1'($urandom);
        bv      = 1'($urandom);
        ja_drv  = jv;
        bez_drv = bv;
        run     = 1'($urandom);
      end
      mpc = (jv || (bv && zv)) ? int'(ins[3:0]) : (mpc + 1) % 16;
      tick();
      check("next_fetch_iv", 32'(instr_valid), 32'd0);
      check("next_fetch_pc", 32'(pc), 32'(mpc));
    end
    run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    safe_ops[0] = 3'd0;
    safe_ops[1] = 3'd3;
    safe_ops[2] = 3'd4;
    safe_ops[3] = 3'd5;
    safe_ops[4] = 3'd6;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_opcode", 32'(opcode), 32'd7);
    check("rst_operand", 32'(operand), 32'd0);
    check("rst_iv", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    rst_n = 1'b1;
    tick();

    run_and_check(4, 1'b1, 0);

    prog_q.delete();
    prog_q.push_back(8'h05); prog_q.push_back(8'h60); prog_q.push_back(8'hE0);
    load_prog(0);
    run_and_check(6, 1'b1, 0);

    prog_q.delete();
    prog_q.push_back(8'h25);
    for (int i = 0; i < 4; i++) prog_q.push_back(8'h00);
    prog_q.push_back(8'hE0);
    load_prog(0);
    run_and_check(4, 1'b1, 0);

    prog_q.delete();
    prog_q.push_back(8'h49); prog_q.push_back(8'hE0);
    load_prog(0);
    run_and_check(4, 1'b1, 0);
    run_and_check(4, 1'b1, 1);

    prog_q.delete();
    for (int i = 0; i < 17; i++) begin
      prog_q.push_back({safe_ops[$urandom_range(4)], 5'($urandom)});
    end
    load_prog(3);
    run_and_check(17, 1'b1, 0);

    for (int it = 0; it < 6; it++) begin
      prog_q.delete();
      for (int i = 0; i < int'($urandom_range(20, 1)); i++) prog_q.push_back(8'($urandom));
      load_prog(int'($urandom_range(7)));
      run_and_check(30, 1'b0, 2);
    end

    prog_q.delete();
    prog_q.push_back(8'h00); prog_q.push_back(8'h00); prog_q.push_back(8'hE0);
    load_prog(0);
    use_dec = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (3) tick();
    check("mid_exec_iv", 32'(instr_valid), 32'd1);
    check("mid_exec_pc", 32'(pc), 32'd1);
    load_en = 1'b1;
    tick();
    check("abort_loading", 32'(loading), 32'd1);
    check("abort_iv", 32'(instr_valid), 32'd0);
    check("abort_pc", 32'(pc), 32'd1);
    run       = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    repeat (3) tick();
    check("run_ignored_in_load", 32'(loading), 32'd1);
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_loading", 32'(loading), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_opcode", 32'(opcode), 32'd7);
    model_reset();
    load_en   = 1'b0;
    ser_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    run_and_check(3, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
